// File: rtl/seg_scan_if.sv
// Bundle of display data inputs and scanned LED outputs for seg_scan_ctrl.
// master drives the data side; slave is the scan controller.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [3:0]              brightness;
  logic                    load;
  logic [NUM_DIGITS-1:0]   seg_an;
  logic [7:0]              seg_seg;
  logic                    frame_done;

  modport master (
    output disp_data, dp_mask, digit_en, lz_blank, brightness, load,
    input  seg_an, seg_seg, frame_done
  );

  modport slave (
    input  disp_data, dp_mask, digit_en, lz_blank, brightness, load,
    output seg_an, seg_seg, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with PWM brightness, guard phase,
// leading-zero blanking and frame-synchronised data loading.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned SCAN_HZ    = 4_000,
  parameter int unsigned HEX_EN     = 1
) (
  input logic       clk,
  input logic       rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned Div    = CLK_HZ / SCAN_HZ;
  localparam int unsigned SubDiv = Div / 16;
  localparam int unsigned PreW   = (SubDiv > 1) ? $clog2(SubDiv) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned DataW  = 4 * NUM_DIGITS;

  // Slot counter split into prescaler and 16-phase sub counter: cnt = sub*SubDiv + pre.
  logic [PreW-1:0]       pre_q, pre_d;
  logic [3:0]            sub_q, sub_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DataW-1:0]      act_data_q, act_data_d, pnd_data_q, pnd_data_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d, pnd_dp_q, pnd_dp_d;
  logic [NUM_DIGITS-1:0] act_en_q, act_en_d, pnd_en_q, pnd_en_d;
  logic                  pend_q, pend_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_done_q;

  logic                  pre_end, slot_end, wrap;
  logic [NUM_DIGITS-1:0] blank;
  logic                  higher_zero;
  logic [3:0]            nib;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    logic [7:0] g;
    unique case (v)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      4'hF: g = 8'h8E;
      default: g = 8'hFF;
    endcase
    if (HEX_EN == 0 && v > 4'd9) g = 8'hFF;
    return g;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q        <= '0;
      sub_q        <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '1;
      pnd_data_q   <= '0;
      pnd_dp_q     <= '0;
      pnd_en_q     <= '1;
      pend_q       <= 1'b0;
      an_q         <= '1;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      sub_q        <= sub_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pnd_data_q   <= pnd_data_d;
      pnd_dp_q     <= pnd_dp_d;
      pnd_en_q     <= pnd_en_d;
      pend_q       <= pend_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= wrap;
    end
  end

  // Next-state: counters and shadow data.
  always_comb begin
    pre_end  = (pre_q == PreW'(SubDiv - 1));
    slot_end = pre_end && (sub_q == 4'hF);
    wrap     = slot_end && (idx_q == IdxW'(NUM_DIGITS - 1));

    pre_d = pre_end ? '0 : pre_q + 1'b1;
    sub_d = pre_end ? sub_q + 4'd1 : sub_q;
    idx_d = idx_q;
    if (slot_end) idx_d = wrap ? '0 : idx_q + 1'b1;

    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    pnd_data_d = pnd_data_q;
    pnd_dp_d   = pnd_dp_q;
    pnd_en_d   = pnd_en_q;
    pend_d     = pend_q;

    if (bus.load) begin
      pnd_data_d = bus.disp_data;
      pnd_dp_d   = bus.dp_mask;
      pnd_en_d   = bus.digit_en;
      pend_d     = 1'b1;
    end
    // A load landing on the wrap itself bypasses the pending stage.
    if (wrap) begin
      if (bus.load) begin
        act_data_d = bus.disp_data;
        act_dp_d   = bus.dp_mask;
        act_en_d   = bus.digit_en;
        pend_d     = 1'b0;
      end else if (pend_q) begin
        act_data_d = pnd_data_q;
        act_dp_d   = pnd_dp_q;
        act_en_d   = pnd_en_q;
        pend_d     = 1'b0;
      end
    end
  end

  // Blanking scans from the most significant digit down, tracking "all higher are zero".
  always_comb begin
    blank       = '0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero & (act_data_q[4*k +: 4] == 4'h0);
      blank[k]    = !act_en_q[k] | (bus.lz_blank & higher_zero & (k != 0));
    end
  end

  // Output decode; registered so seg_an/seg_seg trail the counters by one clock.
  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    nib   = act_data_q[4*int'(idx_q) +: 4];
    if (sub_q != 4'h0 && sub_q <= bus.brightness && !blank[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = glyph(nib);
      if (act_dp_q[idx_q]) seg_d[7] = 1'b0;
    end
  end

  assign bus.seg_an     = an_q;
  assign bus.seg_seg    = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl at DIV=16: table of load vectors checked frame by frame
// through a scoreboard, plus reset, mid-frame load and wrap-coincident load sequences.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if #(.NUM_DIGITS(4)) bus1 ();
  seg_scan_if #(.NUM_DIGITS(4)) bus2 ();

  seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_HZ(1600), .SCAN_HZ(100), .HEX_EN(1)) dut_hex (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_HZ(1600), .SCAN_HZ(100), .HEX_EN(0)) dut_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus2.disp_data  = bus1.disp_data;
  assign bus2.dp_mask    = bus1.dp_mask;
  assign bus2.digit_en   = bus1.digit_en;
  assign bus2.lz_blank   = bus1.lz_blank;
  assign bus2.brightness = bus1.brightness;
  assign bus2.load       = bus1.load;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
    logic [3:0]  br;
    logic [31:0] segs;   // {d3,d2,d1,d0} segment byte while lit, FF if dark
    logic [3:0]  lit;
    logic        dec_dark;
  } vec_t;

  typedef struct {
    logic [31:0] segs;
    logic [3:0]  lit;
    logic [3:0]  br;
    logic        dec_dark;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] segs, input logic [3:0] lit,
                          input logic [3:0] br, input logic dec_dark);
    exp_t e;
    e.segs = segs;
    e.lit = lit;
    e.br = br;
    e.dec_dark = dec_dark;
    sb_q.push_back(e);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (bus1.frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("frame_sync", {31'd0, bus1.frame_done}, 32'd1);
  endtask

  // Starts on a negedge where frame_done is high; observes the following 64 clocks.
  task automatic run_frame(input int la, input logic [15:0] da, input int lb,
                           input logic [15:0] db);
    int         on[4];
    logic [7:0] seen[4];
    int         viol = 0;
    int         fd_bad = 0;
    int         dec_lit = 0;
    int         pos, dig;
    exp_t       e;
    for (int k = 0; k < 4; k++) begin
      on[k] = 0;
      seen[k] = 8'hFF;
    end
    for (int s = 1; s <= 64; s++) begin
      @(negedge clk);
      if (bus1.load) begin
        bus1.load = 1'b0;
        bus1.disp_data = 16'hFFFF;
      end
      pos = (s - 1) % 16;
      dig = (s - 1) / 16;
      if (bus1.seg_an == 4'hF) begin
        if (bus1.seg_seg != 8'hFF) viol++;
      end else if (bus1.seg_an == ~(4'b0001 << dig)) begin
        on[dig]++;
        if (pos == 0 || pos > int'(bus1.brightness)) viol++;
        if (on[dig] == 1) seen[dig] = bus1.seg_seg;
        else if (seen[dig] != bus1.seg_seg) viol++;
      end else begin
        viol++;
      end
      if (bus2.seg_seg != 8'hFF) dec_lit++;
      if ((s == 64) != (bus1.frame_done == 1'b1)) fd_bad++;
      if (s == la) begin
        bus1.disp_data = da;
        bus1.load = 1'b1;
      end
      if (s == lb) begin
        bus1.disp_data = db;
        bus1.load = 1'b1;
      end
    end
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb_q.pop_front();
      for (int k = 0; k < 4; k++) begin
        check($sformatf("on_time_d%0d", k), on[k], e.lit[k] ? int'(e.br) : 0);
        check($sformatf("segs_d%0d", k), {24'd0, seen[k]}, {24'd0, e.segs[8*k +: 8]});
      end
      check("scan_shape", viol, 0);
      check("frame_done_period", fd_bad, 0);
      if (e.dec_dark) check("hex_en0_blank", dec_lit, 0);
    end
  endtask

  task automatic reset_seq(input string tag);
    int first = 0;
    logic [3:0] an_first = 4'hF;
    logic [7:0] seg_first = 8'hFF;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_an"}, {28'd0, bus1.seg_an}, 32'hF);
    check({tag, "_seg"}, {24'd0, bus1.seg_seg}, 32'hFF);
    check({tag, "_fd"}, {31'd0, bus1.frame_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      if (first == 0 && bus1.seg_an != 4'hF) begin
        first = s;
        an_first = bus1.seg_an;
        seg_first = bus1.seg_seg;
      end
    end
    check({tag, "_first_lit_clk"}, first, 2);
    check({tag, "_first_an"}, {28'd0, an_first}, 32'hE);
    check({tag, "_first_seg"}, {24'd0, seg_first}, 32'hC0);
  endtask

  initial begin
    vecs[0] = '{16'h1A3F, 4'h0, 4'hF, 1'b0, 4'd15, {8'hF9, 8'h88, 8'hB0, 8'h8E}, 4'hF, 1'b0};
    vecs[1] = '{16'h0050, 4'h2, 4'hF, 1'b1, 4'd15, {8'hFF, 8'hFF, 8'h12, 8'hC0}, 4'h3, 1'b0};
    vecs[2] = '{16'h0000, 4'h0, 4'hF, 1'b1, 4'd15, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'h1, 1'b0};
    vecs[3] = '{16'h1234, 4'h0, 4'hF, 1'b0, 4'd4,  {8'hF9, 8'hA4, 8'hB0, 8'h99}, 4'hF, 1'b0};
    vecs[4] = '{16'h1234, 4'h0, 4'hF, 1'b0, 4'd0,  {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'h0, 1'b0};
    vecs[5] = '{16'h8888, 4'hF, 4'hA, 1'b0, 4'd8,  {8'h00, 8'hFF, 8'h00, 8'hFF}, 4'hA, 1'b0};
    vecs[6] = '{16'h0607, 4'h0, 4'hF, 1'b1, 4'd10, {8'hFF, 8'h82, 8'hC0, 8'hF8}, 4'h7, 1'b0};
    vecs[7] = '{16'hBCDE, 4'h0, 4'hF, 1'b0, 4'd15, {8'h83, 8'hC6, 8'hA1, 8'h86}, 4'hF, 1'b1};

    bus1.disp_data  = 16'h0000;
    bus1.dp_mask    = 4'h0;
    bus1.digit_en   = 4'hF;
    bus1.lz_blank   = 1'b0;
    bus1.brightness = 4'd15;
    bus1.load       = 1'b0;

    reset_seq("reset");

    foreach (vecs[i]) begin
      bus1.disp_data  = vecs[i].data;
      bus1.dp_mask    = vecs[i].dp;
      bus1.digit_en   = vecs[i].en;
      bus1.lz_blank   = vecs[i].lz;
      bus1.brightness = vecs[i].br;
      bus1.load       = 1'b1;
      push_exp(vecs[i].segs, vecs[i].lit, vecs[i].br, vecs[i].dec_dark);
      @(negedge clk);
      bus1.load = 1'b0;
      bus1.disp_data = 16'hFFFF;
      wait_frame();
      run_frame(-1, 16'h0, -1, 16'h0);
    end

    // Two loads mid-frame: current frame keeps old data, next frame shows the later load.
    push_exp({8'h83, 8'hC6, 8'hA1, 8'h86}, 4'hF, 4'd15, 1'b1);
    run_frame(10, 16'h1111, 30, 16'h5678);
    // Pending load then a load on the wrap cycle: the wrap-cycle load wins.
    push_exp({8'h92, 8'h82, 8'hF8, 8'h80}, 4'hF, 4'd15, 1'b0);
    run_frame(10, 16'h9999, 63, 16'h00B5);
    push_exp({8'hC0, 8'hC0, 8'h83, 8'h92}, 4'hF, 4'd15, 1'b0);
    run_frame(-1, 16'h0, -1, 16'h0);
    push_exp({8'hC0, 8'hC0, 8'h83, 8'h92}, 4'hF, 4'd15, 1'b0);
    run_frame(-1, 16'h0, -1, 16'h0);

    repeat (21) @(negedge clk);
    reset_seq("mid_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
